// File: rtl/debounce_edge_pkg.sv
// Shared state encodings for the debounce FSM and the later edge/counter stages.
// The encodings are fixed, so every stage that imports this package agrees on them.
package debounce_edge_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_LOW    = 2'b00,
    ST_WAIT_H = 2'b01,
    ST_HIGH   = 2'b10,
    ST_WAIT_L = 2'b11
  } dbnc_state_t;

endpackage

// File: rtl/debounce_edge_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit (d -> s1 -> s2).
// q_next is the value q takes on the next edge, for consumers that qualify that edge.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_next
);

  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
    end
  end

  assign q      = s2_reg;
  assign q_next = s1_reg;

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw asynchronous input into a clean level.
// Also produces single-cycle rise/fall pulses and a busy flag while a change is being qualified.
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_raw,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        s2;
  logic        s2_next;
  dbnc_state_t state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic        dout_reg;
  logic        rise_reg;
  logic        fall_reg;
  logic        busy_reg;

  sync_2ff u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (din_raw),
    .q      (s2),
    .q_next (s2_next)
  );

  // The FSM judges the value s2 takes on this very edge, so the edge on which
  // s2 first differs from dout is count 1 and dout moves on count STABLE_CYCLES+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_LOW;
      cnt_reg   <= '0;
      dout_reg  <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        ST_LOW: begin
          if (s2_next) begin
            state_reg <= ST_WAIT_H;
            cnt_reg   <= CNT_ONE;
            busy_reg  <= 1'b1;
          end
        end
        ST_WAIT_H: begin
          if (!(s2_next && s2)) begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg <= ST_HIGH;
            cnt_reg   <= '0;
            dout_reg  <= 1'b1;
            rise_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!s2_next) begin
            state_reg <= ST_WAIT_L;
            cnt_reg   <= CNT_ONE;
            busy_reg  <= 1'b1;
          end
        end
        ST_WAIT_L: begin
          if (s2_next || s2) begin
            state_reg <= ST_HIGH;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
            fall_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_LOW;
          cnt_reg   <= '0;
          dout_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: fixed vector table for reset/rise/fall, then a
// run-length reference model feeding a scoreboard for glitches, alternation and aborts.
module tb_debounce_edge;

  localparam int SC = 4;

  logic clk;
  logic rst_n;
  logic din_raw;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  debounce_edge #(.STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_raw    (din_raw),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } exp_t;

  typedef struct packed {
    logic rst_n;
    logic din;
    exp_t exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  // Reference model: s1/s2 pipeline plus a run length of mismatching s2 values.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_dout = 1'b0;
  int   m_run = 0;

  task automatic chk(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0b, expected %0b", name, cyc, act, req);
    end
  endtask

  task automatic model_step(input logic r, input logic d, output exp_t e);
    e = '0;
    if (!r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_run = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = d;
      if (m_s2 != m_dout) begin
        m_run++;
        if (m_run == SC + 1) begin
          m_dout = m_s2;
          m_run  = 0;
          e.rise = m_dout;
          e.fall = !m_dout;
        end
      end else begin
        m_run = 0;
      end
    end
    e.dout = m_dout;
    e.busy = (m_run != 0);
  endtask

  // One clock: drive inputs, push model expectation, compare just after the edge.
  task automatic step(input logic r, input logic d);
    exp_t e;
    exp_t got;
    rst_n   = r;
    din_raw = d;
    model_step(r, d, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = sb_q.pop_front();
    $display("cyc %0d rst_n=%0b din=%0b -> dout=%0b rise=%0b fall=%0b busy=%0b",
             cyc, r, d, dout, rise_pulse, fall_pulse, busy);
    chk("dout", dout, got.dout);
    chk("rise_pulse", rise_pulse, got.rise);
    chk("fall_pulse", fall_pulse, got.fall);
    chk("busy", busy, got.busy);
    chk("pulse_exclusive", rise_pulse & fall_pulse, 1'b0);
    chk("pulse_while_busy", busy & (rise_pulse | fall_pulse), 1'b0);
  endtask

  vec_t vecs[16];
  int   pulses;
  logic seen_busy;

  initial begin
    rst_n   = 1'b0;
    din_raw = 1'b1;

    // {rst_n, din, {dout, rise, fall, busy}} after each edge
    vecs[0]  = {1'b0, 1'b1, 4'b0000};
    vecs[1]  = {1'b0, 1'b1, 4'b0000};
    vecs[2]  = {1'b1, 1'b1, 4'b0000};
    vecs[3]  = {1'b1, 1'b1, 4'b0001};
    vecs[4]  = {1'b1, 1'b1, 4'b0001};
    vecs[5]  = {1'b1, 1'b1, 4'b0001};
    vecs[6]  = {1'b1, 1'b1, 4'b0001};
    vecs[7]  = {1'b1, 1'b1, 4'b1100};
    vecs[8]  = {1'b1, 1'b1, 4'b1000};
    vecs[9]  = {1'b1, 1'b0, 4'b1000};
    vecs[10] = {1'b1, 1'b0, 4'b1001};
    vecs[11] = {1'b1, 1'b0, 4'b1001};
    vecs[12] = {1'b1, 1'b0, 4'b1001};
    vecs[13] = {1'b1, 1'b0, 4'b1001};
    vecs[14] = {1'b1, 1'b0, 4'b0010};
    vecs[15] = {1'b1, 1'b0, 4'b0000};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst_n, vecs[i].din);
      chk("tbl_dout", dout, vecs[i].exp.dout);
      chk("tbl_rise", rise_pulse, vecs[i].exp.rise);
      chk("tbl_fall", fall_pulse, vecs[i].exp.fall);
      chk("tbl_busy", busy, vecs[i].exp.busy);
    end

    // Glitch of 3 cycles: busy must show up, dout must not move.
    seen_busy = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1); seen_busy |= busy; pulses += rise_pulse; end
    for (int i = 0; i < 8; i++) begin step(1'b1, 1'b0); seen_busy |= busy; pulses += rise_pulse; end
    chk("glitch_busy_seen", seen_busy, 1'b1);
    chk("glitch_no_rise", pulses != 0, 1'b0);
    chk("glitch_dout", dout, 1'b0);

    // Boundary: SC cycles high is rejected, SC+1 cycles high is accepted.
    for (int i = 0; i < SC; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < SC + 1; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("boundary_rise_dout", dout, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("boundary_fall_dout", dout, 1'b0);

    // Alternating every cycle: no level change, no pulses.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, logic'(i % 2 == 0));
      pulses += rise_pulse + fall_pulse;
    end
    chk("alt_no_pulse", pulses != 0, 1'b0);
    chk("alt_dout", dout, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

    // Reset at count 2 of a rise aborts it; full latency applies afterwards.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("abort_busy_before", busy, 1'b1);
    step(1'b0, 1'b1);
    chk("abort_busy_after", busy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin step(1'b1, 1'b1); pulses += rise_pulse; end
    chk("abort_no_early_rise", pulses != 0, 1'b0);
    step(1'b1, 1'b1);
    chk("abort_full_latency_rise", rise_pulse, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

    // Noisy input with occasional long stable runs.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic lvl;
        lvl = logic'($urandom_range(0, 1));
        for (int j = 0; j < 7; j++) step(1'b1, lvl);
      end else begin
        step(1'b1, logic'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
